tx_session_scheduler: RTL and testbench

- Sequences the TCP TX path for the gradient kernel.
- For each outgoing session it issues a TX metadata request to the TCP stack and waits for the TX status word. It then grants or kills exactly one data packet (TLAST-delimited) on the outgoing data stream.
- Sits between the session-meta FIFO / result data FIFO and the stack's m_axis_tx_metadata / m_axis_tx_data interfaces, replacing the ad-hoc token/kill logic in the top level.

---
 rtl/tx_session_scheduler.sv | 121 ++++++++++++
 tb/tb_tx_session_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_session_scheduler.sv
// tx_session_scheduler: issues TX metadata per session, retries on no-space, and grants or kills one packet per decision
module tx_session_scheduler #(
  parameter int PKT_LEN        = 64,
  parameter int GRANT_DEPTH    = 8,
  parameter int RETRY_MAX      = 4,
  parameter int BACKOFF_CYCLES = 256
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_axis_meta_TVALID,
  output logic         s_axis_meta_TREADY,
  input  logic [63:0]  s_axis_meta_TDATA,
  output logic         m_axis_tx_metadata_TVALID,
  input  logic         m_axis_tx_metadata_TREADY,
  output logic [31:0]  m_axis_tx_metadata_TDATA,
  input  logic         s_axis_tx_status_TVALID,
  output logic         s_axis_tx_status_TREADY,
  input  logic [63:0]  s_axis_tx_status_TDATA,
  input  logic         s_axis_data_TVALID,
  output logic         s_axis_data_TREADY,
  input  logic [511:0] s_axis_data_TDATA,
  input  logic         s_axis_data_TLAST,
  output logic         m_axis_tx_data_TVALID,
  input  logic         m_axis_tx_data_TREADY,
  output logic [511:0] m_axis_tx_data_TDATA,
  output logic [63:0]  m_axis_tx_data_TKEEP,
  output logic         m_axis_tx_data_TLAST,
  output logic [7:0]   grant_count,
  output logic [15:0]  drop_count
);
  localparam int PW = $clog2(GRANT_DEPTH);
  localparam int CW = $clog2(GRANT_DEPTH + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int BW = $clog2(BACKOFF_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, BACKOFF} state_t;
  state_t           r_state;
  logic [RW-1:0]    r_retry;
  logic [BW-1:0]    r_bo;
  logic             r_md_valid;
  logic [31:0]      r_md_data;
  logic [GRANT_DEPTH-1:0] r_q;
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_drop;
  logic [1:0]       w_code;
  logic             w_full, w_empty, w_pass, w_status, w_retry, w_push, w_kill, w_pop;
  logic             w_unused;
  assign w_unused = ^{s_axis_meta_TDATA[63:16], s_axis_tx_status_TDATA[61:0]};
  assign w_code   = s_axis_tx_status_TDATA[63:62];
  assign w_full   = r_cnt == CW'(GRANT_DEPTH);
  assign w_empty  = r_cnt == '0;
  assign w_pass   = r_q[r_rp];
  assign w_status = (r_state == WAIT) && s_axis_tx_status_TVALID;
  assign w_retry  = w_status && (w_code == 2'd2) && (r_retry < RW'(RETRY_MAX));
  assign w_push   = w_status && !w_retry;
  assign w_kill   = w_push && (w_code != 2'd0);
  assign w_pop    = s_axis_data_TVALID && s_axis_data_TREADY && s_axis_data_TLAST;
  assign s_axis_meta_TREADY        = (r_state == IDLE) && !w_full;
  assign s_axis_tx_status_TREADY   = 1'b1;
  assign m_axis_tx_metadata_TVALID = r_md_valid;
  assign m_axis_tx_metadata_TDATA  = r_md_data;
  assign m_axis_tx_data_TVALID     = !w_empty && w_pass && s_axis_data_TVALID;
  assign s_axis_data_TREADY        = !w_empty && (w_pass ? m_axis_tx_data_TREADY : 1'b1);
  assign m_axis_tx_data_TDATA      = s_axis_data_TDATA;
  assign m_axis_tx_data_TLAST      = s_axis_data_TLAST;
  assign m_axis_tx_data_TKEEP      = '1;
  assign grant_count               = 8'(r_cnt);
  assign drop_count                = r_drop;
  // Session sequencer: accept meta, request, await status, back off between no-space retries
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state    <= IDLE;
      r_retry    <= '0;
      r_bo       <= '0;
      r_md_valid <= 1'b0;
      r_md_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (s_axis_meta_TVALID && !w_full) begin
          r_md_data  <= {16'(PKT_LEN), s_axis_meta_TDATA[15:0]};
          r_md_valid <= 1'b1;
          r_retry    <= RW'(1);
          r_state    <= SEND;
        end
        SEND: if (m_axis_tx_metadata_TREADY) begin
          r_md_valid <= 1'b0;
          r_state    <= WAIT;
        end
        WAIT: if (s_axis_tx_status_TVALID) begin
          r_bo    <= '0;
          r_retry <= w_retry ? r_retry + 1'b1 : r_retry;
          r_state <= w_retry ? BACKOFF : IDLE;
        end
        BACKOFF: if (r_bo == BW'(BACKOFF_CYCLES)) begin
          r_md_valid <= 1'b1;
          r_state    <= SEND;
        end else begin
          r_bo <= r_bo + 1'b1;
        end
      endcase
    end
  // Grant queue: one PASS/KILL bit per session, popped on the accepted TLAST beat
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_q   <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wp] <= ~w_kill;
        r_wp      <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  // Saturating count of killed packets
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_drop <= '0;
    else if (w_kill && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
endmodule

// File: tb/tb_tx_session_scheduler.sv
// tb_tx_session_scheduler: randomized scenario bench against a decision-queue reference model
module tb_tx_session_scheduler;
  localparam int GD = 8;
  localparam int RM = 4;
  localparam int BO = 16;
  localparam int PKT_LEN = 64;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_axis_meta_TVALID, s_axis_meta_TREADY;
  logic [63:0]  s_axis_meta_TDATA;
  logic         m_axis_tx_metadata_TVALID, m_axis_tx_metadata_TREADY;
  logic [31:0]  m_axis_tx_metadata_TDATA;
  logic         s_axis_tx_status_TVALID, s_axis_tx_status_TREADY;
  logic [63:0]  s_axis_tx_status_TDATA;
  logic         s_axis_data_TVALID, s_axis_data_TREADY;
  logic [511:0] s_axis_data_TDATA;
  logic         s_axis_data_TLAST;
  logic         m_axis_tx_data_TVALID, m_axis_tx_data_TREADY;
  logic [511:0] m_axis_tx_data_TDATA;
  logic [63:0]  m_axis_tx_data_TKEEP;
  logic         m_axis_tx_data_TLAST;
  logic [7:0]   grant_count;
  logic [15:0]  drop_count;
  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  int cyc = 0;
  bit dq[$];

  tx_session_scheduler #(.PKT_LEN(PKT_LEN), .GRANT_DEPTH(GD), .RETRY_MAX(RM), .BACKOFF_CYCLES(BO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_meta_TVALID(s_axis_meta_TVALID), .s_axis_meta_TREADY(s_axis_meta_TREADY), .s_axis_meta_TDATA(s_axis_meta_TDATA),
    .m_axis_tx_metadata_TVALID(m_axis_tx_metadata_TVALID), .m_axis_tx_metadata_TREADY(m_axis_tx_metadata_TREADY),
    .m_axis_tx_metadata_TDATA(m_axis_tx_metadata_TDATA),
    .s_axis_tx_status_TVALID(s_axis_tx_status_TVALID), .s_axis_tx_status_TREADY(s_axis_tx_status_TREADY),
    .s_axis_tx_status_TDATA(s_axis_tx_status_TDATA),
    .s_axis_data_TVALID(s_axis_data_TVALID), .s_axis_data_TREADY(s_axis_data_TREADY),
    .s_axis_data_TDATA(s_axis_data_TDATA), .s_axis_data_TLAST(s_axis_data_TLAST),
    .m_axis_tx_data_TVALID(m_axis_tx_data_TVALID), .m_axis_tx_data_TREADY(m_axis_tx_data_TREADY),
    .m_axis_tx_data_TDATA(m_axis_tx_data_TDATA), .m_axis_tx_data_TKEEP(m_axis_tx_data_TKEEP),
    .m_axis_tx_data_TLAST(m_axis_tx_data_TLAST),
    .grant_count(grant_count), .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axis_meta_TVALID = 0;
    s_axis_meta_TDATA = '0;
    m_axis_tx_metadata_TREADY = 0;
    s_axis_tx_status_TVALID = 0;
    s_axis_tx_status_TDATA = '0;
    s_axis_data_TVALID = 0;
    s_axis_data_TDATA = '0;
    s_axis_data_TLAST = 0;
    m_axis_tx_data_TREADY = 0;
  endtask

  task automatic offer_meta(input logic [15:0] sid, output bit ok);
    s_axis_meta_TDATA = {32'($urandom), 16'($urandom), sid};
    s_axis_meta_TVALID = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = s_axis_meta_TREADY;
      tick();
    end
    s_axis_meta_TVALID = 0;
  endtask

  // Model: attempts stop at the first non-2 code or at RETRY_MAX; PASS only if that final code is 0.
  task automatic run_session(input logic [15:0] sid, input logic [2*RM+1:0] codes);
    int att, reqs, n, t_hs;
    bit ok, pass;
    att = RM;
    for (int i = RM - 1; i >= 0; i--) if (codes[2*i +: 2] != 2'd2) att = i + 1;
    pass = codes[2*(att-1) +: 2] == 2'd0;
    offer_meta(sid, ok);
    checks++;
    if (!ok || m_axis_tx_metadata_TVALID !== 1'b1)
      begin errors++; $display("FAIL meta_accept sid=%h: accepted=%0b md_valid=%b, required accepted=1 md_valid=1", sid, ok, m_axis_tx_metadata_TVALID); end
    reqs = 0;
    t_hs = -1;
    for (int a = 0; a <= RM; a++) begin
      n = 0;
      while (m_axis_tx_metadata_TVALID !== 1'b1 && n < BO + 8) begin
        s_axis_tx_status_TVALID = $urandom_range(0, 3) == 0;
        s_axis_tx_status_TDATA = {2'($urandom_range(0, 3)), 62'($urandom)};
        tick();
        s_axis_tx_status_TVALID = 0;
        n++;
      end
      if (m_axis_tx_metadata_TVALID !== 1'b1) break;
      reqs++;
      if (t_hs >= 0) begin
        checks++;
        if (cyc - t_hs != BO + 1)
          begin errors++; $display("FAIL backoff_delay sid=%h: got %0d cycles, required %0d", sid, cyc - t_hs, BO + 1); end
      end
      repeat ($urandom_range(0, 2)) tick();
      checks++;
      if (m_axis_tx_metadata_TVALID !== 1'b1 || m_axis_tx_metadata_TDATA !== {16'(PKT_LEN), sid})
        begin errors++; $display("FAIL md_request: valid=%b data=%h, required valid=1 data=%h", m_axis_tx_metadata_TVALID, m_axis_tx_metadata_TDATA, {16'(PKT_LEN), sid}); end
      m_axis_tx_metadata_TREADY = 1;
      tick();
      m_axis_tx_metadata_TREADY = 0;
      checks++;
      if (m_axis_tx_metadata_TVALID !== 1'b0 || s_axis_tx_status_TREADY !== 1'b1)
        begin errors++; $display("FAIL md_done: md_valid=%b status_ready=%b, required 0 and 1", m_axis_tx_metadata_TVALID, s_axis_tx_status_TREADY); end
      repeat ($urandom_range(0, 2)) tick();
      s_axis_tx_status_TVALID = 1;
      s_axis_tx_status_TDATA = {codes[2*a +: 2], 62'($urandom)};
      tick();
      t_hs = cyc;
      s_axis_tx_status_TVALID = 0;
    end
    dq.push_back(pass);
    if (!pass) exp_drop++;
    checks++;
    if (reqs != att)
      begin errors++; $display("FAIL req_count sid=%h: got %0d requests, required %0d", sid, reqs, att); end
    checks++;
    if (drop_count !== 16'(exp_drop) || grant_count !== 8'(dq.size()))
      begin errors++; $display("FAIL queue_state sid=%h: drop=%0d grant=%0d, required drop=%0d grant=%0d", sid, drop_count, grant_count, exp_drop, dq.size()); end
  endtask

  task automatic send_packet(input int beats, input bit rnd);
    bit pass, acc;
    int n;
    logic [511:0] d;
    pass = dq[0];
    for (int b = 0; b < beats; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      s_axis_data_TDATA = d;
      s_axis_data_TLAST = b == beats - 1;
      acc = 0;
      n = 0;
      while (!acc && n < 40) begin
        s_axis_data_TVALID = !rnd || n > 20 || $urandom_range(0, 3) != 0;
        m_axis_tx_data_TREADY = !rnd || n > 20 || $urandom_range(0, 1) != 0;
        #1;
        checks++;
        if (m_axis_tx_data_TVALID !== (pass & s_axis_data_TVALID) || s_axis_data_TREADY !== (pass ? m_axis_tx_data_TREADY : 1'b1))
          begin errors++; $display("FAIL gate pass=%0b: out_valid=%b in_ready=%b, required %b %b", pass, m_axis_tx_data_TVALID, s_axis_data_TREADY, pass & s_axis_data_TVALID, pass ? m_axis_tx_data_TREADY : 1'b1); end
        if (pass && s_axis_data_TVALID) begin
          checks++;
          if (m_axis_tx_data_TDATA !== d || m_axis_tx_data_TLAST !== (b == beats - 1) || m_axis_tx_data_TKEEP !== {64{1'b1}})
            begin errors++; $display("FAIL beat %0d: last=%b keep=%h data_ok=%0b, required last=%0b keep=all ones data_ok=1", b, m_axis_tx_data_TLAST, m_axis_tx_data_TKEEP, m_axis_tx_data_TDATA === d, b == beats - 1); end
        end
        acc = s_axis_data_TVALID && s_axis_data_TREADY;
        tick();
        n++;
      end
      s_axis_data_TVALID = 0;
      if (!acc) begin checks++; errors++; $display("FAIL beat_timeout beat %0d: not accepted, required accept", b); end
    end
    void'(dq.pop_front());
    checks++;
    if (grant_count !== 8'(dq.size()))
      begin errors++; $display("FAIL grant_pop: got %0d, required %0d", grant_count, dq.size()); end
  endtask

  task automatic pulse_reset();
    #2 aresetn = 0;
    #1;
    checks++;
    if (m_axis_tx_metadata_TVALID !== 0 || m_axis_tx_data_TVALID !== 0 || m_axis_tx_metadata_TDATA !== '0 || grant_count !== 0 || drop_count !== 0)
      begin errors++; $display("FAIL async_reset: md_valid=%b data_valid=%b md_data=%h grant=%0d drop=%0d, required all 0", m_axis_tx_metadata_TVALID, m_axis_tx_data_TVALID, m_axis_tx_metadata_TDATA, grant_count, drop_count); end
    idle_inputs();
    dq.delete();
    exp_drop = 0;
    @(negedge aclk);
    aresetn = 1;
    tick();
    checks++;
    if (s_axis_meta_TREADY !== 1'b1)
      begin errors++; $display("FAIL post_reset_idle: meta_ready=%b, required 1", s_axis_meta_TREADY); end
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 0;
    repeat (2) tick();
    checks++;
    if (m_axis_tx_metadata_TVALID !== 0 || m_axis_tx_data_TVALID !== 0 || m_axis_tx_metadata_TDATA !== '0 || grant_count !== 0 || drop_count !== 0)
      begin errors++; $display("FAIL reset_state: md_valid=%b data_valid=%b md_data=%h grant=%0d drop=%0d, required all 0", m_axis_tx_metadata_TVALID, m_axis_tx_data_TVALID, m_axis_tx_metadata_TDATA, grant_count, drop_count); end
    @(negedge aclk);
    aresetn = 1;
    tick();
    s_axis_data_TVALID = 1;
    m_axis_tx_data_TREADY = 1;
    #1;
    checks++;
    if (s_axis_meta_TREADY !== 1 || s_axis_tx_status_TREADY !== 1 || m_axis_tx_data_TVALID !== 0 || s_axis_data_TREADY !== 0)
      begin errors++; $display("FAIL empty_idle: meta_ready=%b status_ready=%b out_valid=%b in_ready=%b, required 1 1 0 0", s_axis_meta_TREADY, s_axis_tx_status_TREADY, m_axis_tx_data_TVALID, s_axis_data_TREADY); end
    idle_inputs();
    tick();
  endtask

  task automatic test_pass();
    run_session(16'h0005, '0);
    send_packet(3, 0);
  endtask

  task automatic test_kill();
    run_session(16'h0007, 10'h001);
    send_packet(2, 1);
  endtask

  task automatic test_retry_once();
    run_session(16'h0031, 10'h002);
    send_packet(2, 1);
  endtask

  task automatic test_retry_max();
    run_session(16'h0042, 10'h0AA);
    run_session(16'h0043, '0);
    send_packet(2, 1);
    send_packet(3, 1);
  endtask

  task automatic test_full();
    for (int i = 0; i < GD; i++) run_session(16'(16'h0100 + i), '0);
    s_axis_meta_TVALID = 1;
    repeat (3) begin
      #1;
      checks++;
      if (s_axis_meta_TREADY !== 1'b0 || grant_count !== 8'(GD))
        begin errors++; $display("FAIL full_block: meta_ready=%b grant=%0d, required 0 and %0d", s_axis_meta_TREADY, grant_count, GD); end
      tick();
    end
    s_axis_meta_TVALID = 0;
    send_packet(1, 1);
    checks++;
    if (s_axis_meta_TREADY !== 1'b1)
      begin errors++; $display("FAIL full_release: meta_ready=%b, required 1", s_axis_meta_TREADY); end
    run_session(16'h0108, '0);
    for (int i = 0; i < GD; i++) send_packet($urandom_range(1, 4), 1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    run_session(16'h0011, 10'h001);
    run_session(16'h0012, '0);
    send_packet(2, 1);
    s_axis_data_TVALID = 1;
    m_axis_tx_data_TREADY = 1;
    s_axis_data_TLAST = 0;
    s_axis_data_TDATA = 512'h1111;
    tick();
    s_axis_data_TDATA = 512'h2222;
    pulse_reset();
    run_session(16'h0021, '0);
    run_session(16'h0022, 10'h003);
    offer_meta(16'h0023, ok);
    m_axis_tx_metadata_TREADY = 1;
    tick();
    m_axis_tx_metadata_TREADY = 0;
    pulse_reset();
    run_session(16'h0024, '0);
    send_packet(3, 1);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, GD);
      for (int s = 0; s < n; s++) run_session(16'($urandom), 10'($urandom));
      for (int s = 0; s < n; s++) send_packet($urandom_range(1, 5), 1);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_kill();
    test_retry_once();
    test_retry_max();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
